// File: rtl/melody_sequencer.sv
// Score-ROM sequencer for the square-wave tone generator: walks a fixed score at a tick-based
// tempo and hands the generator a divider, gate and load strobe per step, mirroring the note on the LEDs.
module melody_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_DIV  = 6_250_000,
  parameter int GAP_TICKS = 1,
  parameter int SCORE_LEN = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        play,
  input  logic        stop,
  input  logic        loop_en,
  output logic [20:0] half_period,
  output logic        gate,
  output logic        note_valid,
  output logic [2:0]  note_idx,
  output logic [3:0]  step,
  output logic        busy,
  output logic [9:0]  led
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_STEP = 4'(SCORE_LEN - 1);
  localparam logic [7:0]    GAP_LOAD  = 8'(GAP_TICKS);
  localparam logic [2:0]    REST      = 3'd7;

  typedef enum logic [1:0] {IDLE, FETCH, SOUND, GAP} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    dur_cnt;
  logic [7:0]    gap_cnt;
  logic [6:0]    entry;
  logic [2:0]    rom_note;
  logic [3:0]    rom_len;
  logic          marker;
  logic          tick;
  logic          note_done;
  logic          advance;
  logic          to_idle;

  // Score entry is {note, len}; len of zero marks the end of the score.
  function automatic logic [6:0] rom_entry(input logic [3:0] idx);
    if (idx < 4'd7)
      return {idx[2:0], 4'd8};
    else if (idx == 4'd7)
      return {REST, 4'd4};
    else
      return 7'd0;
  endfunction

  function automatic logic [20:0] divider(input logic [2:0] n);
    case (n)
      3'd0:    return 21'(CLK_HZ / (2 * 523));
      3'd1:    return 21'(CLK_HZ / (2 * 587));
      3'd2:    return 21'(CLK_HZ / (2 * 659));
      3'd3:    return 21'(CLK_HZ / (2 * 698));
      3'd4:    return 21'(CLK_HZ / (2 * 783));
      3'd5:    return 21'(CLK_HZ / (2 * 880));
      3'd6:    return 21'(CLK_HZ / (2 * 987));
      default: return 21'd0;
    endcase
  endfunction

  // Stop, an unlooped marker and an unlooped end-of-score all collapse into one return to IDLE.
  always_comb begin
    entry     = rom_entry(step);
    rom_note  = entry[6:4];
    rom_len   = entry[3:0];
    marker    = (rom_len == 4'd0);
    tick      = (tick_cnt == TICK_LAST);
    note_done = (state == SOUND) && tick && (dur_cnt == 4'd1);
    advance   = (note_done && (GAP_TICKS == 0))
             || ((state == GAP) && tick && (gap_cnt == 8'd1));
    to_idle   = stop
             || ((state == FETCH) && marker && ((step == 4'd0) || !loop_en))
             || (advance && (step == LAST_STEP) && !loop_en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      half_period <= '0;
      gate        <= 1'b0;
      note_valid  <= 1'b0;
      note_idx    <= '0;
      step        <= '0;
      busy        <= 1'b0;
      led         <= '0;
      tick_cnt    <= '0;
      dur_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      note_valid <= 1'b0;
      if (to_idle) begin
        state       <= IDLE;
        busy        <= 1'b0;
        gate        <= 1'b0;
        led         <= '0;
        half_period <= '0;
        tick_cnt    <= '0;
        dur_cnt     <= '0;
        gap_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (play) begin
              step  <= '0;
              busy  <= 1'b1;
              state <= FETCH;
            end
          end
          FETCH: begin
            if (marker) begin
              step <= '0;
            end else begin
              half_period <= divider(rom_note);
              note_idx    <= rom_note;
              gate        <= (rom_note != REST);
              led         <= (rom_note == REST) ? 10'd0 : (10'd1 << rom_note);
              dur_cnt     <= rom_len;
              tick_cnt    <= '0;
              note_valid  <= 1'b1;
              state       <= SOUND;
            end
          end
          SOUND: begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick)
              dur_cnt <= dur_cnt - 4'd1;
            if (note_done) begin
              gate <= 1'b0;
              led  <= '0;
              if (GAP_TICKS > 0) begin
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end
            end
          end
          GAP: begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick)
              gap_cnt <= gap_cnt - 8'd1;
          end
          default: state <= IDLE;
        endcase
        // The last ROM slot wraps to 0; an unlooped wrap was already caught by to_idle.
        if (advance) begin
          state <= FETCH;
          step  <= (step == LAST_STEP) ? 4'd0 : step + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a gapped instance and a legato instance, each with a strobe
// scoreboard fed by the directed sequence and drained by its own monitor.
module tb_melody_sequencer;

  localparam int TD = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        play_a, stop_a, loop_a, play_b, stop_b, loop_b;
  logic [20:0] half_a, half_b;
  logic        gate_a, gate_b, nv_a, nv_b, busy_a, busy_b;
  logic [2:0]  idx_a, idx_b;
  logic [3:0]  step_a, step_b;
  logic [9:0]  led_a, led_b;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_a = 0;
  int last_b = 0;

  typedef struct {
    logic [20:0] half;
    logic [2:0]  idx;
    logic        gate;
    logic [9:0]  led;
    logic [3:0]  step;
    int          gap;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  melody_sequencer #(.CLK_HZ(100_000_000), .TICK_DIV(TD), .GAP_TICKS(1), .SCORE_LEN(16)) dut_a (
    .clock(clock), .reset(reset), .play(play_a), .stop(stop_a), .loop_en(loop_a),
    .half_period(half_a), .gate(gate_a), .note_valid(nv_a), .note_idx(idx_a),
    .step(step_a), .busy(busy_a), .led(led_a)
  );

  melody_sequencer #(.CLK_HZ(100_000_000), .TICK_DIV(TD), .GAP_TICKS(0), .SCORE_LEN(16)) dut_b (
    .clock(clock), .reset(reset), .play(play_b), .stop(stop_b), .loop_en(loop_b),
    .half_period(half_b), .gate(gate_b), .note_valid(nv_b), .note_idx(idx_b),
    .step(step_b), .busy(busy_b), .led(led_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int div_of(input int s);
    case (s)
      0: return 95602;
      1: return 85178;
      2: return 75872;
      3: return 71633;
      4: return 63856;
      5: return 56818;
      6: return 50658;
      default: return 0;
    endcase
  endfunction

  // Expected strobe for a score step; gap is the strobe-to-strobe spacing (0 = not checked).
  function automatic exp_t mk(input int s, input int gap);
    exp_t e;
    e.step = 4'(s);
    e.gap  = gap;
    if (s < 7) begin
      e.idx  = 3'(s);
      e.half = 21'(div_of(s));
      e.gate = 1'b1;
      e.led  = 10'd1 << s;
    end else begin
      e.idx  = 3'd7;
      e.half = 21'd0;
      e.gate = 1'b0;
      e.led  = 10'd0;
    end
    return e;
  endfunction

  initial begin : monitor_a
    exp_t e;
    forever begin
      @(negedge clock);
      if (nv_a === 1'b1) begin
        if (qa.size() == 0) begin
          check_output("a.unexpected_strobe", {28'd0, step_a}, 32'hFFFF_FFFF);
        end else begin
          e = qa.pop_front();
          check_output("a.half_period", half_a, e.half);
          check_output("a.note_idx", idx_a, e.idx);
          check_output("a.gate", gate_a, e.gate);
          check_output("a.led", led_a, e.led);
          check_output("a.step", step_a, e.step);
          if (e.gap > 0)
            check_output("a.spacing", cyc - last_a, e.gap);
        end
        last_a = cyc;
      end
    end
  end

  initial begin : monitor_b
    exp_t e;
    forever begin
      @(negedge clock);
      if (nv_b === 1'b1) begin
        if (qb.size() == 0) begin
          check_output("b.unexpected_strobe", {28'd0, step_b}, 32'hFFFF_FFFF);
        end else begin
          e = qb.pop_front();
          check_output("b.half_period", half_b, e.half);
          check_output("b.note_idx", idx_b, e.idx);
          check_output("b.gate", gate_b, e.gate);
          check_output("b.led", led_b, e.led);
          check_output("b.step", step_b, e.step);
          if (e.gap > 0)
            check_output("b.spacing", cyc - last_b, e.gap);
        end
        last_b = cyc;
      end
    end
  end

  task automatic apply_stimulus(input bit sel, input logic p, input logic s, output int start);
    @(negedge clock);
    start = cyc;
    if (sel) begin play_b = p; stop_b = s; end
    else     begin play_a = p; stop_a = s; end
    @(negedge clock);
    play_a = 1'b0; stop_a = 1'b0; play_b = 1'b0; stop_b = 1'b0;
  endtask

  task automatic wait_strobe(input bit sel, input string tag, output int at);
    int n = 0;
    at = -1;
    while (n < 3000 && at < 0) begin
      if ((sel ? nv_b : nv_a) === 1'b1) at = cyc;
      else begin @(negedge clock); n++; end
    end
    if (at < 0) check_output({tag, ".strobe_timeout"}, 0, 1);
  endtask

  task automatic measure_gate(input bit sel, output int hi, output int lo);
    hi = 0;
    lo = 0;
    while ((sel ? gate_b : gate_a) === 1'b1 && hi < 200) begin hi++; @(negedge clock); end
    while ((sel ? gate_b : gate_a) === 1'b0 && lo < 200) begin lo++; @(negedge clock); end
  endtask

  task automatic wait_sb_a(input int target, input string tag);
    int n = 0;
    while (qa.size() > target && n < 3000) begin @(negedge clock); n++; end
    check_output({tag, ".sb_drain"}, qa.size(), target);
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (busy_a !== 1'b0 && n < 3000) begin @(negedge clock); n++; end
    check_output({tag, ".busy"}, {31'd0, busy_a}, 0);
  endtask

  function automatic void check_idle_a(input string tag, input logic [3:0] exp_step, input logic [2:0] exp_idx);
    check_output({tag, ".busy"}, {31'd0, busy_a}, 0);
    check_output({tag, ".gate"}, {31'd0, gate_a}, 0);
    check_output({tag, ".half_period"}, half_a, 0);
    check_output({tag, ".led"}, led_a, 0);
    check_output({tag, ".note_valid"}, {31'd0, nv_a}, 0);
    check_output({tag, ".step"}, step_a, exp_step);
    check_output({tag, ".note_idx"}, idx_a, exp_idx);
  endfunction

  initial begin : main
    int start, at, hi, lo;
    reset = 1'b1;
    play_a = 1'b0; stop_a = 1'b0; loop_a = 1'b0;
    play_b = 1'b0; stop_b = 1'b0; loop_b = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check_idle_a("reset", 4'd0, 3'd0);

    // Single pass through the score, no loop: 7 notes, one rest, then the marker stops it.
    for (int s = 0; s < 8; s++) qa.push_back(mk(s, (s == 0) ? 0 : 37));
    apply_stimulus(1'b0, 1'b1, 1'b0, start);
    wait_strobe(1'b0, "first", at);
    check_output("first.latency", at - start, 2);
    measure_gate(1'b0, hi, lo);
    check_output("first.gate_high", hi, 32);
    check_output("first.gate_low", lo, 5);
    wait_idle_a("end_noloop");
    check_idle_a("end_noloop", 4'd8, 3'd7);
    wait_sb_a(0, "end_noloop");

    // Simultaneous play and stop in IDLE must not start playback.
    apply_stimulus(1'b0, 1'b1, 1'b1, start);
    check_output("play_stop.busy", {31'd0, busy_a}, 0);
    repeat (3) @(negedge clock);
    check_output("play_stop.busy_later", {31'd0, busy_a}, 0);
    check_output("play_stop.step", step_a, 8);

    // Looping pass: after the rest, the marker costs one extra FETCH before step 0 replays.
    loop_a = 1'b1;
    for (int s = 0; s < 8; s++) qa.push_back(mk(s, (s == 0) ? 0 : 37));
    qa.push_back(mk(0, 22));
    apply_stimulus(1'b0, 1'b1, 1'b0, start);
    wait_sb_a(6, "loop_step2");
    repeat (5) @(negedge clock);
    apply_stimulus(1'b0, 1'b1, 1'b0, start);
    check_output("play_busy.step", step_a, 2);
    check_output("play_busy.half_period", half_a, 75872);
    check_output("play_busy.busy", {31'd0, busy_a}, 1);
    wait_sb_a(0, "loop_wrap");
    repeat (5) @(negedge clock);
    check_output("loop_wrap.gate", {31'd0, gate_a}, 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, start);
    check_idle_a("stop", 4'd0, 3'd0);
    loop_a = 1'b0;

    // Legato instance: back-to-back notes with a single FETCH cycle of silence.
    qb.push_back(mk(0, 0));
    qb.push_back(mk(1, 33));
    qb.push_back(mk(2, 33));
    apply_stimulus(1'b1, 1'b1, 1'b0, start);
    wait_strobe(1'b1, "legato", at);
    check_output("legato.latency", at - start, 2);
    measure_gate(1'b1, hi, lo);
    check_output("legato.gate_high", hi, 32);
    check_output("legato.gate_low", lo, 1);
    repeat (40) @(negedge clock);
    check_output("legato.sb_drain", qb.size(), 0);
    apply_stimulus(1'b1, 1'b0, 1'b1, start);
    check_output("legato.stop_busy", {31'd0, busy_b}, 0);
    check_output("legato.stop_gate", {31'd0, gate_b}, 0);

    // Reset in the middle of a sounding note clears everything, including step and note_idx.
    qa.push_back(mk(0, 0));
    apply_stimulus(1'b0, 1'b1, 1'b0, start);
    wait_sb_a(0, "reset_mid");
    repeat (8) @(negedge clock);
    check_output("reset_mid.gate_before", {31'd0, gate_a}, 1);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_idle_a("reset_mid", 4'd0, 3'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_a("after_reset", 4'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
